hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 3-stage core (IF/ID, EX, MEM/WB). It sequences stalls, bubbles and squashes around the EX/MEM control logic:
- load-use hazards between ID and EX;
- redirects from EX (taken branch, jal, jalr) with a configurable fetch-latency flush window;
- multi-cycle data-memory accesses that answer with an ack, bounded by a timeout.

All pipeline-register enables and kills in the core come from this block.

---
 rtl/hazard_ctrl_if.sv | 36 +++
 rtl/hazard_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Pipeline-side signals of the hazard controller. The core
//               drives instructions and memory status; the controller drives
//               stalls, bubbles and squashes.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if;
    logic [31:0] inst_id;
    logic [31:0] inst_ex;
    logic        pc_sel_ex;
    logic        dmem_req;
    logic        dmem_ack;
    logic        stall_fetch;
    logic        stall_ex;
    logic        stall_mem;
    logic        bubble_ex;
    logic        flush_id;
    logic        pc_redirect_en;
    logic        mem_timeout;
    logic [1:0]  state;

    modport master (
        output inst_id, inst_ex, pc_sel_ex, dmem_req, dmem_ack,
        input  stall_fetch, stall_ex, stall_mem, bubble_ex, flush_id,
               pc_redirect_en, mem_timeout, state
    );

    modport slave (
        input  inst_id, inst_ex, pc_sel_ex, dmem_req, dmem_ack,
        output stall_fetch, stall_ex, stall_mem, bubble_ex, flush_id,
               pc_redirect_en, mem_timeout, state
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Stall/bubble/squash sequencer for the 3-stage core: load-use,
//               EX redirects with a fetch flush window, slow dmem with timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int WAIT_TIMEOUT = 255
) (
    input  wire logic     clk,
    input  wire logic     rst,
    hazard_ctrl_if.slave  hz
);

    localparam int c_fcnt_w = $clog2(FLUSH_CYCLES) + 1;
    localparam int c_wcnt_w = $clog2(WAIT_TIMEOUT + 1);

    localparam logic [c_fcnt_w-1:0] c_flush_reload = c_fcnt_w'(FLUSH_CYCLES - 1);
    localparam logic [c_fcnt_w-1:0] c_fcnt_one     = c_fcnt_w'(1);
    localparam logic [c_fcnt_w-1:0] c_fcnt_zero    = '0;
    localparam logic [c_wcnt_w-1:0] c_wait_max     = c_wcnt_w'(WAIT_TIMEOUT);
    localparam logic [c_wcnt_w-1:0] c_wcnt_one     = c_wcnt_w'(1);
    localparam logic [c_wcnt_w-1:0] c_wcnt_zero    = '0;
    localparam logic                c_has_window   = (FLUSH_CYCLES > 1);

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_FLUSH   = 2'd1,
        S_MEMWAIT = 2'd2,
        S_UNUSED  = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_fcnt_w-1:0]   r_flush_cnt;
    logic [c_wcnt_w-1:0]   r_wait_cnt;
    logic                  r_mem_timeout;

    state_t                w_state_nxt;
    logic [c_fcnt_w-1:0]   w_flush_cnt_nxt;
    logic [c_wcnt_w-1:0]   w_wait_cnt_nxt;
    logic                  w_timeout_set;
    logic                  w_stall_all;
    logic                  w_stall_fetch;
    logic                  w_bubble_ex;
    logic                  w_flush_id;
    logic                  w_redirect;

    // ------------------------------------------------------------------
    // Load-use decode
    // ------------------------------------------------------------------
    logic [6:0] w_op_ex;
    logic [4:0] w_rd_ex;
    logic [6:0] w_op_id;
    logic [4:0] w_rs1_id;
    logic [4:0] w_rs2_id;
    logic       w_uses_rs1;
    logic       w_uses_rs2;
    logic       w_load_use;
    logic       w_mem_pending;
    logic       w_unused;

    assign w_op_ex  = hz.inst_ex[6:0];
    assign w_rd_ex  = hz.inst_ex[11:7];
    assign w_op_id  = hz.inst_id[6:0];
    assign w_rs1_id = hz.inst_id[19:15];
    assign w_rs2_id = hz.inst_id[24:20];
    assign w_unused = &{1'b0, hz.inst_ex[31:12], hz.inst_id[31:25], hz.inst_id[14:7]};

    // Store rs2 is forwarded from MEM, so only R-type and branches count here.
    assign w_uses_rs1 = !((w_op_id == c_op_lui) || (w_op_id == c_op_auipc) ||
                          (w_op_id == c_op_jal));
    assign w_uses_rs2 = (w_op_id == c_op_rtype) || (w_op_id == c_op_branch);
    assign w_load_use = (w_op_ex == c_op_load) && (w_rd_ex != 5'd0) &&
                        ((w_uses_rs1 && (w_rs1_id == w_rd_ex)) ||
                         (w_uses_rs2 && (w_rs2_id == w_rd_ex)));

    assign w_mem_pending = hz.dmem_req && !hz.dmem_ack;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_RUN;
            r_flush_cnt   <= c_fcnt_zero;
            r_wait_cnt    <= c_wcnt_zero;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_flush_cnt   <= w_flush_cnt_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_mem_timeout <= r_mem_timeout | w_timeout_set;
        end
    end

    // ------------------------------------------------------------------
    // Next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_timeout_set   = 1'b0;
        w_stall_all     = 1'b0;
        w_stall_fetch   = 1'b0;
        w_bubble_ex     = 1'b0;
        w_flush_id      = 1'b0;
        w_redirect      = 1'b0;

        case (r_state)
            S_RUN: begin
                if (w_mem_pending) begin
                    w_stall_all    = 1'b1;
                    w_wait_cnt_nxt = c_wcnt_one;
                    w_state_nxt    = S_MEMWAIT;
                end else if (hz.pc_sel_ex) begin
                    w_flush_id  = 1'b1;
                    w_bubble_ex = 1'b1;
                    w_redirect  = 1'b1;
                    if (c_has_window) begin
                        w_flush_cnt_nxt = c_flush_reload;
                        w_state_nxt     = S_FLUSH;
                    end
                end else if (w_load_use) begin
                    w_stall_fetch = 1'b1;
                    w_bubble_ex   = 1'b1;
                end
            end

            S_FLUSH: begin
                // A slow access freezes the remaining flush window until it ends.
                if (w_mem_pending) begin
                    w_stall_all    = 1'b1;
                    w_wait_cnt_nxt = c_wcnt_one;
                    w_state_nxt    = S_MEMWAIT;
                end else begin
                    w_flush_id = 1'b1;
                    if (hz.pc_sel_ex) begin
                        w_bubble_ex     = 1'b1;
                        w_redirect      = 1'b1;
                        w_flush_cnt_nxt = c_flush_reload;
                    end else if (r_flush_cnt <= c_fcnt_one) begin
                        w_flush_cnt_nxt = c_fcnt_zero;
                        w_state_nxt     = S_RUN;
                    end else begin
                        w_flush_cnt_nxt = r_flush_cnt - c_fcnt_one;
                    end
                end
            end

            S_MEMWAIT: begin
                if (hz.dmem_ack || (r_wait_cnt >= c_wait_max)) begin
                    w_timeout_set  = !hz.dmem_ack;
                    w_wait_cnt_nxt = c_wcnt_zero;
                    w_state_nxt    = (r_flush_cnt != c_fcnt_zero) ? S_FLUSH : S_RUN;
                end else begin
                    w_stall_all    = 1'b1;
                    w_wait_cnt_nxt = r_wait_cnt + c_wcnt_one;
                end
            end

            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // Outputs are forced low for the whole time reset is held.
    assign hz.stall_fetch    = rst & (w_stall_all | w_stall_fetch);
    assign hz.stall_ex       = rst & w_stall_all;
    assign hz.stall_mem      = rst & w_stall_all;
    assign hz.bubble_ex      = rst & w_bubble_ex;
    assign hz.flush_id       = rst & w_flush_id;
    assign hz.pc_redirect_en = rst & w_redirect;
    assign hz.mem_timeout    = rst & r_mem_timeout;
    assign hz.state          = rst ? r_state : 2'd0;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Scoreboard bench driving two hazard_ctrl instances
//               (FLUSH_CYCLES 2 and 3, WAIT_TIMEOUT 8) with the same vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam logic [31:0] c_nop     = 32'h00000013;
    localparam logic [31:0] c_lw_x5   = 32'h0000A283;  // lw  x5,0(x1)
    localparam logic [31:0] c_lw_x0   = 32'h0000A003;  // lw  x0,0(x1)
    localparam logic [31:0] c_add_rs1 = 32'h00228333;  // add x6,x5,x2
    localparam logic [31:0] c_add_rs2 = 32'h00510333;  // add x6,x2,x5
    localparam logic [31:0] c_add_x0  = 32'h00200333;  // add x6,x0,x2
    localparam logic [31:0] c_sw_x5   = 32'h0051A023;  // sw  x5,0(x3)
    localparam logic [31:0] c_lui_rs5 = 32'h00028337;  // lui x6 with rs1 field = 5

    logic clk;
    logic rst;
    int   tests    = 0;
    int   failures = 0;

    hazard_ctrl_if bus_a ();
    hazard_ctrl_if bus_b ();

    hazard_ctrl #(.FLUSH_CYCLES(2), .WAIT_TIMEOUT(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .hz  (bus_a)
    );

    hazard_ctrl #(.FLUSH_CYCLES(3), .WAIT_TIMEOUT(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .hz  (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [8:0] ea;
        logic [8:0] eb;
    } exp_t;

    exp_t sb_q[$];

    // {stall_fetch, stall_ex, stall_mem, bubble_ex, flush_id, pc_redirect_en, mem_timeout, state}
    function automatic logic [8:0] mk(input logic sf, input logic se, input logic sm,
                                      input logic be, input logic fi, input logic pr,
                                      input logic mt, input logic [1:0] st);
        return {sf, se, sm, be, fi, pr, mt, st};
    endfunction

    function automatic logic [8:0] stall(input logic mt, input logic [1:0] st);
        return mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mt, st);
    endfunction

    function automatic logic [8:0] quiet(input logic mt, input logic [1:0] st);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mt, st);
    endfunction

    task automatic drive(input logic [31:0] ex, input logic [31:0] id,
                         input logic ps, input logic rq, input logic ak);
        bus_a.inst_ex = ex;  bus_b.inst_ex = ex;
        bus_a.inst_id = id;  bus_b.inst_id = id;
        bus_a.pc_sel_ex = ps; bus_b.pc_sel_ex = ps;
        bus_a.dmem_req  = rq; bus_b.dmem_req  = rq;
        bus_a.dmem_ack  = ak; bus_b.dmem_ack  = ak;
    endtask

    task automatic step(input string nm, input logic [8:0] ea, input logic [8:0] eb);
        sb_q.push_back('{nm, ea, eb});
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expectation per cycle and checks both instances.
    always @(negedge clk) begin
        exp_t       e;
        logic [8:0] got_a;
        logic [8:0] got_b;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            got_a = {bus_a.stall_fetch, bus_a.stall_ex, bus_a.stall_mem, bus_a.bubble_ex,
                     bus_a.flush_id, bus_a.pc_redirect_en, bus_a.mem_timeout, bus_a.state};
            got_b = {bus_b.stall_fetch, bus_b.stall_ex, bus_b.stall_mem, bus_b.bubble_ex,
                     bus_b.flush_id, bus_b.pc_redirect_en, bus_b.mem_timeout, bus_b.state};
            tests++;
            if (got_a !== e.ea) begin
                failures++;
                $display("FAIL %s [F2] got=%b expected=%b", e.name, got_a, e.ea);
            end
            tests++;
            if (got_b !== e.eb) begin
                failures++;
                $display("FAIL %s [F3] got=%b expected=%b", e.name, got_b, e.eb);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish, failed=%0d", failures);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        drive(c_nop, c_nop, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Outputs stay low under reset even with every trigger active
        drive(c_lw_x5, c_add_rs1, 1'b1, 1'b1, 1'b0);
        step("rst_outputs", quiet(0, 0), quiet(0, 0));
        drive(c_nop, c_nop, 1'b0, 1'b0, 1'b0);
        step("rst_hold", quiet(0, 0), quiet(0, 0));
        rst = 1'b1;
        step("idle", quiet(0, 0), quiet(0, 0));

        // Load-use decode
        drive(c_lw_x5, c_add_rs1, 1'b0, 1'b0, 1'b0);
        step("lu_rs1", mk(1,0,0,1,0,0,0,0), mk(1,0,0,1,0,0,0,0));
        drive(c_nop, c_add_rs1, 1'b0, 1'b0, 1'b0);
        step("lu_after_bubble", quiet(0, 0), quiet(0, 0));
        drive(c_lw_x5, c_add_rs2, 1'b0, 1'b0, 1'b0);
        step("lu_rs2", mk(1,0,0,1,0,0,0,0), mk(1,0,0,1,0,0,0,0));
        drive(c_lw_x0, c_add_x0, 1'b0, 1'b0, 1'b0);
        step("lu_rd_x0", quiet(0, 0), quiet(0, 0));
        drive(c_lw_x5, c_sw_x5, 1'b0, 1'b0, 1'b0);
        step("lu_store_rs2", quiet(0, 0), quiet(0, 0));
        drive(c_lw_x5, c_lui_rs5, 1'b0, 1'b0, 1'b0);
        step("lu_lui", quiet(0, 0), quiet(0, 0));

        // Redirect; load-use inside the window is ignored
        drive(c_nop, c_nop, 1'b1, 1'b0, 1'b0);
        step("redir_T", mk(0,0,0,1,1,1,0,0), mk(0,0,0,1,1,1,0,0));
        drive(c_lw_x5, c_add_rs1, 1'b0, 1'b0, 1'b0);
        step("redir_T1", mk(0,0,0,0,1,0,0,1), mk(0,0,0,0,1,0,0,1));
        step("redir_T2", mk(1,0,0,1,0,0,0,0), mk(0,0,0,0,1,0,0,1));
        drive(c_nop, c_nop, 1'b0, 1'b0, 1'b0);
        step("redir_T3", quiet(0, 0), quiet(0, 0));

        // Slow access acked in its 4th cycle
        drive(c_nop, c_nop, 1'b0, 1'b1, 1'b0);
        step("mw_c1", stall(0, 0), stall(0, 0));
        step("mw_c2", stall(0, 2), stall(0, 2));
        step("mw_c3", stall(0, 2), stall(0, 2));
        drive(c_nop, c_nop, 1'b0, 1'b1, 1'b1);
        step("mw_ack", quiet(0, 2), quiet(0, 2));
        drive(c_nop, c_nop, 1'b0, 1'b0, 1'b0);
        step("mw_after", quiet(0, 0), quiet(0, 0));
        drive(c_nop, c_nop, 1'b0, 1'b1, 1'b1);
        step("req_ack_same", quiet(0, 0), quiet(0, 0));

        // Priority: memory over redirect over load-use; redirect held through MEMWAIT
        drive(c_lw_x5, c_add_rs1, 1'b1, 1'b1, 1'b0);
        step("prio_mem", stall(0, 0), stall(0, 0));
        drive(c_lw_x5, c_add_rs1, 1'b1, 1'b0, 1'b0);
        step("prio_wait", stall(0, 2), stall(0, 2));
        drive(c_lw_x5, c_add_rs1, 1'b1, 1'b0, 1'b1);
        step("prio_ack", quiet(0, 2), quiet(0, 2));
        drive(c_lw_x5, c_add_rs1, 1'b1, 1'b0, 1'b0);
        step("prio_redir", mk(0,0,0,1,1,1,0,0), mk(0,0,0,1,1,1,0,0));
        drive(c_nop, c_nop, 1'b0, 1'b0, 1'b0);
        step("prio_f1", mk(0,0,0,0,1,0,0,1), mk(0,0,0,0,1,0,0,1));
        step("prio_f2", quiet(0, 0), mk(0,0,0,0,1,0,0,1));
        step("prio_done", quiet(0, 0), quiet(0, 0));

        // Slow access interrupting a flush window; remaining window resumes
        drive(c_nop, c_nop, 1'b1, 1'b0, 1'b0);
        step("t5_T", mk(0,0,0,1,1,1,0,0), mk(0,0,0,1,1,1,0,0));
        drive(c_nop, c_nop, 1'b0, 1'b1, 1'b0);
        step("t5_T1", stall(0, 1), stall(0, 1));
        step("t5_w1", stall(0, 2), stall(0, 2));
        step("t5_w2", stall(0, 2), stall(0, 2));
        drive(c_nop, c_nop, 1'b0, 1'b1, 1'b1);
        step("t5_ack", quiet(0, 2), quiet(0, 2));
        drive(c_nop, c_nop, 1'b0, 1'b0, 1'b0);
        step("t5_f1", mk(0,0,0,0,1,0,0,1), mk(0,0,0,0,1,0,0,1));
        step("t5_f2", quiet(0, 0), mk(0,0,0,0,1,0,0,1));
        step("t5_run", quiet(0, 0), quiet(0, 0));

        // Timeout with no ack
        drive(c_nop, c_nop, 1'b0, 1'b1, 1'b0);
        step("to_c1", stall(0, 0), stall(0, 0));
        for (int i = 1; i <= 7; i++)
            step($sformatf("to_wait%0d", i), stall(0, 2), stall(0, 2));
        drive(c_nop, c_nop, 1'b0, 1'b0, 1'b0);
        step("to_release", quiet(0, 2), quiet(0, 2));
        step("to_sticky", quiet(1, 0), quiet(1, 0));
        drive(c_lw_x5, c_add_rs1, 1'b0, 1'b0, 1'b0);
        step("to_sticky_lu", mk(1,0,0,1,0,0,1,0), mk(1,0,0,1,0,0,1,0));
        drive(c_nop, c_nop, 1'b0, 1'b1, 1'b1);
        step("to_sticky_ack", quiet(1, 0), quiet(1, 0));

        // Reset in the middle of MEMWAIT, then a fresh access counts from 1
        drive(c_nop, c_nop, 1'b0, 1'b1, 1'b0);
        step("rs_c1", stall(1, 0), stall(1, 0));
        for (int i = 1; i <= 4; i++)
            step($sformatf("rs_wait%0d", i), stall(1, 2), stall(1, 2));
        rst = 1'b0;
        step("rs_low", quiet(0, 0), quiet(0, 0));
        step("rs_hold", quiet(0, 0), quiet(0, 0));
        rst = 1'b1;
        step("rs_c1_again", stall(0, 0), stall(0, 0));
        for (int i = 1; i <= 7; i++)
            step($sformatf("rs_again_wait%0d", i), stall(0, 2), stall(0, 2));
        drive(c_nop, c_nop, 1'b0, 1'b0, 1'b0);
        step("rs_again_release", quiet(0, 2), quiet(0, 2));
        step("rs_again_sticky", quiet(1, 0), quiet(1, 0));

        for (int i = 0; i < 10 && sb_q.size() > 0; i++)
            @(negedge clk);
        if (sb_q.size() > 0) begin
            failures++;
            $display("FAIL drain %0d expectations left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
`default_nettype wire
